// File: rtl/sv_uart_rx.sv
// sv_uart_rx: AXI-Stream UART receiver (1 start, DATA_WIDTH data bits LSB-first, STOP_BITS stop bits).
// Optional macro SV_UART_RX_MAJORITY_EN: 2-of-3 majority around each bit centre, decisions one clock later.
module sv_uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  iclk,
  input  logic                  irst_n,
  input  logic                  irx,
  input  logic [15:0]           idivider,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  ooverrun,
  output logic                  obusy
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  localparam logic [4:0] LAST_BIT  = 5'(DATA_WIDTH - 1);
  localparam logic [1:0] LAST_STOP = 2'(STOP_BITS - 1);

  logic                  sync1_q, rx_s_q, rx_d_q;
  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           div_q, div_d;
  logic [4:0]            bitcnt_q, bitcnt_d;
  logic [1:0]            stopcnt_q, stopcnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  ferr_q, ferr_d, ferr_nxt;
  logic                  tvalid_q, tvalid_d;
  logic                  tuser_q, tuser_d;
  logic                  ovr_q, ovr_d;
  logic                  fall, tick, strobe, bit_v, load;

  // Two-flop synchronizer plus one delay flop for falling-edge detection.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_d_q  <= 1'b1;
    end else begin
      sync1_q <= irx;
      rx_s_q  <= sync1_q;
      rx_d_q  <= rx_s_q;
    end
  end

  assign fall = rx_d_q & ~rx_s_q;
  assign tick = (state_q != ST_IDLE) && (cnt_q == 16'd0);

`ifdef SV_UART_RX_MAJORITY_EN
  logic rx_dd_q, tick_q;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      rx_dd_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      rx_dd_q <= rx_d_q;
      tick_q  <= tick;
    end
  end

  // One clock after the tick, rx_d_q holds the centre sample with its neighbours on either side.
  assign strobe = tick_q && (state_q != ST_IDLE);
  assign bit_v  = (rx_s_q & rx_d_q) | (rx_s_q & rx_dd_q) | (rx_d_q & rx_dd_q);
`else
  assign strobe = tick;
  assign bit_v  = rx_s_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bitcnt_d  = bitcnt_q;
    stopcnt_d = stopcnt_q;
    shreg_d   = shreg_q;
    ferr_d    = ferr_q;
    ferr_nxt  = ferr_q | ~bit_v;
    load      = 1'b0;

    // Divider is captured once per frame; the first strobe lands half a bit after the edge.
    if (state_q == ST_IDLE) begin
      if (fall) begin
        state_d = ST_START;
        cnt_d   = idivider >> 1;
        div_d   = idivider;
      end
    end else if (cnt_q == 16'd0) begin
      cnt_d = div_q - 16'd1;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end

    if (strobe) begin
      case (state_q)
        ST_START: begin
          if (bit_v) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_DATA;
            bitcnt_d = '0;
          end
        end
        ST_DATA: begin
          shreg_d  = {bit_v, shreg_q[DATA_WIDTH-1:1]};
          bitcnt_d = bitcnt_q + 5'd1;
          if (bitcnt_q == LAST_BIT) begin
            state_d   = ST_STOP;
            stopcnt_d = '0;
            ferr_d    = 1'b0;
          end
        end
        ST_STOP: begin
          ferr_d    = ferr_nxt;
          stopcnt_d = stopcnt_q + 2'd1;
          if (stopcnt_q == LAST_STOP) begin
            state_d = ST_IDLE;
            load    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A completed word always wins; overrun only when the held word was not taken this cycle.
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    ovr_d    = 1'b0;
    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = shreg_q;
      tuser_d  = ferr_nxt;
      ovr_d    = tvalid_q & ~m_axis_tready;
    end else if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      bitcnt_q  <= '0;
      stopcnt_q <= '0;
      shreg_q   <= '0;
      ferr_q    <= 1'b0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tuser_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bitcnt_q  <= bitcnt_d;
      stopcnt_q <= stopcnt_d;
      shreg_q   <= shreg_d;
      ferr_q    <= ferr_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tuser_q   <= tuser_d;
      ovr_q     <= ovr_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tuser  = tuser_q;
  assign ooverrun      = ovr_q;
  assign obusy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sv_uart_rx.sv
// Scoreboard bench for sv_uart_rx: stimulus pushes expected words, a monitor pops them on each handshake.
`timescale 1ns/1ps
module tb_sv_uart_rx;

  typedef struct {
    logic [7:0] data;
    logic       user;
    longint     cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        irx0, irx1;
  logic [15:0] div0, div1;
  logic [7:0]  tdata0, tdata1;
  logic        tvalid0, tvalid1, tready0, tready1;
  logic        tuser0, tuser1, ovr0, ovr1, busy0, busy1;
  longint      cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          ovr_cnt0 = 0;
  int          ovr_cnt1 = 0;
  exp_t        q0[$];
  exp_t        q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sv_uart_rx #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut (
    .iclk(clk), .irst_n(rst_n), .irx(irx0), .idivider(div0),
    .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tready(tready0),
    .m_axis_tuser(tuser0), .ooverrun(ovr0), .obusy(busy0)
  );

  sv_uart_rx #(.DATA_WIDTH(8), .STOP_BITS(2)) u_dut2 (
    .iclk(clk), .irst_n(rst_n), .irx(irx1), .idivider(div1),
    .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready1),
    .m_axis_tuser(tuser1), .ooverrun(ovr1), .obusy(busy1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic b);
    if (sel == 0) irx0 = b;
    else          irx1 = b;
  endtask

  // Serial frame generator; the expected word and its tvalid cycle are queued at the start edge.
  task automatic send(input int sel, input logic [7:0] data, input bit stop_low,
                      input int nstop, input int d, input bit push, input bit timed);
    exp_t e;
    @(negedge clk);
    e.data = data;
    e.user = stop_low;
    e.cyc  = timed ? cyc + 3 + d / 2 + (8 + nstop) * d + 1 : -1;
    if (push) begin
      if (sel == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
    drive(sel, 1'b0);
    repeat (d) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(sel, data[i]);
      repeat (d) @(negedge clk);
    end
    for (int i = 0; i < nstop; i++) begin
      drive(sel, ~stop_low);
      repeat (d) @(negedge clk);
    end
    drive(sel, 1'b1);
  endtask

  task automatic check_word(input int sel);
    exp_t       e;
    logic [7:0] d;
    logic       u, b;
    int         n;
    d = (sel == 0) ? tdata0 : tdata1;
    u = (sel == 0) ? tuser0 : tuser1;
    b = (sel == 0) ? busy0  : busy1;
    n = (sel == 0) ? q0.size() : q1.size();
    if (n == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_word%0d: got data=%02h user=%0b, required no word", sel, d, u);
    end else begin
      if (sel == 0) e = q0.pop_front();
      else          e = q1.pop_front();
      chk($sformatf("tdata%0d", sel), 64'(d), 64'(e.data));
      chk($sformatf("tuser%0d", sel), 64'(u), 64'(e.user));
      if (e.cyc >= 0) begin
        chk($sformatf("tvalid_cycle%0d", sel), cyc, e.cyc);
        chk($sformatf("obusy_at_tvalid%0d", sel), 64'(b), 64'd0);
      end
    end
  endtask

  task automatic wait_drain(input int sel, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (((sel == 0) ? q0.size() : q1.size()) == 0) break;
      @(negedge clk);
    end
    chk($sformatf("drained%0d", sel), (sel == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n === 1'b1) begin
        if (ovr0) ovr_cnt0++;
        if (ovr1) ovr_cnt1++;
        if (tvalid0 && tready0) check_word(0);
        if (tvalid1 && tready1) check_word(1);
      end
    end
  end

  initial begin
    longint t0;
    longint base;
    int     oc;
    exp_t   e;
    rst_n = 1'b0; irx0 = 1'b1; irx1 = 1'b1;
    div0 = 16'd16; div1 = 16'd5; tready0 = 1'b1; tready1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tdata",  64'(tdata0),  0);
    chk("rst_tvalid", 64'(tvalid0), 0);
    chk("rst_tuser",  64'(tuser0),  0);
    chk("rst_ovr",    64'(ovr0),    0);
    chk("rst_busy",   64'(busy0),   0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Plain frame with exact tvalid timing.
    send(0, 8'hA5, 1'b0, 1, 16, 1'b1, 1'b1);
    wait_drain(0, 200);

    // Framing error, then a clean frame.
    send(0, 8'h3C, 1'b1, 1, 16, 1'b1, 1'b1);
    repeat (48) @(negedge clk);
    send(0, 8'h5A, 1'b0, 1, 16, 1'b1, 1'b1);
    wait_drain(0, 200);

    // Break: one all-zero word with tuser, no restart while low.
    @(negedge clk);
    e.data = 8'h00; e.user = 1'b1; e.cyc = cyc + 156;
    q0.push_back(e);
    irx0 = 1'b0;
    repeat (480) @(negedge clk);
    irx0 = 1'b1;
    repeat (32) @(negedge clk);
    wait_drain(0, 10);
    send(0, 8'h5A, 1'b0, 1, 16, 1'b1, 1'b1);
    wait_drain(0, 200);

    // Short glitch is rejected as a false start.
    @(negedge clk);
    t0 = cyc;
    irx0 = 1'b0;
    repeat (4) @(negedge clk);
    irx0 = 1'b1;
    while (cyc < t0 + 11) @(negedge clk);
    chk("glitch_busy_before", 64'(busy0), 1);
    @(negedge clk);
    chk("glitch_busy_after", 64'(busy0), 0);
    repeat (200) @(negedge clk);
    chk("glitch_no_tvalid", 64'(tvalid0), 0);

    // Overrun with tready low.
    tready0 = 1'b0;
    oc = ovr_cnt0;
    send(0, 8'h11, 1'b0, 1, 16, 1'b0, 1'b0);
    send(0, 8'h22, 1'b0, 1, 16, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    chk("overrun_pulses", ovr_cnt0 - oc, 1);
    chk("held_tdata", 64'(tdata0), 64'h22);
    chk("held_tvalid", 64'(tvalid0), 1);
    tready0 = 1'b1;
    repeat (10) @(negedge clk);
    chk("queue_after_ready", q0.size(), 0);
    chk("tvalid_after_ready", 64'(tvalid0), 0);

    // Accept and reload in the same cycle: no overrun.
    tready0 = 1'b0;
    oc = ovr_cnt0;
    send(0, 8'h11, 1'b0, 1, 16, 1'b1, 1'b0);
    base = cyc + 1;
    fork
      send(0, 8'h22, 1'b0, 1, 16, 1'b1, 1'b1);
      begin
        while (cyc < base + 155) @(negedge clk);
        tready0 = 1'b1;
      end
    join
    wait_drain(0, 50);
    chk("no_overrun_when_ready", ovr_cnt0 - oc, 0);

    // Two stop bits, fast and slow divider.
    div1 = 16'd5;
    for (int i = 0; i < 16; i++) send(1, 8'($urandom_range(0, 255)), 1'b0, 2, 5, 1'b1, 1'b1);
    wait_drain(1, 200);
    div1 = 16'd868;
    for (int i = 0; i < 3; i++) send(1, 8'($urandom_range(0, 255)), 1'b0, 2, 868, 1'b1, 1'b1);
    wait_drain(1, 2000);
    chk("overrun1", ovr_cnt1, 0);

    // Reset in the middle of data bit 3 discards the frame.
    @(negedge clk);
    irx0 = 1'b0;
    repeat (72) @(negedge clk);
    rst_n = 1'b0;
    irx0 = 1'b1;
    #1;
    chk("midreset_busy", 64'(busy0), 0);
    chk("midreset_tvalid", 64'(tvalid0), 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    send(0, 8'h81, 1'b0, 1, 16, 1'b1, 1'b1);
    wait_drain(0, 200);

    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
